instr_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the MIPS CPU. It fetches 32-bit instructions from instruction memory, latches them into the instruction register feeding the `control` decoder, and steps the datapath through DECODE/EXEC/MEM/WB. It holds memory strobes until each handshake completes and stretches EXEC for the multi-cycle multiplier. It sits between the instruction/data memories and the datapath; PC ownership lives here.

---
 rtl/instr_sequencer_if.sv | 33 +++
 rtl/instr_sequencer.sv | 258 +++++++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Memory-side handshake bundle of the instruction sequencer: instruction fetch
// port and data-memory strobe/ready pair.
interface instr_sequencer_if #(
    parameter int PC_WIDTH = 10
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ready;
    logic [31:0]         imem_data;
    logic                dmem_re;
    logic                dmem_we;
    logic                dmem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_data,
        output dmem_re,
        output dmem_we,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_data,
        input  dmem_re,
        input  dmem_we,
        output dmem_ready
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle MIPS instruction sequencer: owns the PC, fetches into the
// instruction register and walks each instruction through DECODE/EXEC/MEM/WB.
module instr_sequencer #(
    parameter int PC_WIDTH    = 10,
    parameter int MULT_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_sequencer_if.master  mem,
    output logic [31:0]        instr,
    output logic [2:0]         alu_op,
    output logic               alu_en,
    output logic               rf_we,
    output logic               instr_done,
    output logic [15:0]        retire_cnt,
    output logic               halted,
    output logic               illegal
);

    localparam int CNT_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
    localparam logic [PC_WIDTH-1:0] PC_ZERO   = PC_WIDTH'(0);
    localparam logic [PC_WIDTH-1:0] PC_ONE    = PC_WIDTH'(1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        K_ALU   = 3'd0,
        K_LOAD  = 3'd1,
        K_STORE = 3'd2,
        K_NOP   = 3'd3,
        K_HALT  = 3'd4,
        K_ILL   = 3'd5
    } kind_e;

    state_e              state_r;
    kind_e               kind_r;
    kind_e               dec_kind_s;
    logic [2:0]          dec_op_s;
    logic                retire_s;
    logic [CNT_W-1:0]    mcnt_r;
    logic [PC_WIDTH-1:0] pc_r;
    logic [31:0]         instr_r;
    logic [2:0]          alu_op_r;
    logic                alu_en_r;
    logic                imem_req_r;
    logic                dmem_re_r;
    logic                dmem_we_r;
    logic                rf_we_r;
    logic                done_r;
    logic [15:0]         retire_cnt_r;
    logic                halted_r;
    logic                illegal_r;

    assign mem.imem_req  = imem_req_r;
    assign mem.imem_addr = pc_r;
    assign mem.dmem_re   = dmem_re_r;
    assign mem.dmem_we   = dmem_we_r;
    assign instr         = instr_r;
    assign alu_op        = alu_op_r;
    assign alu_en        = alu_en_r;
    assign rf_we         = rf_we_r;
    assign instr_done    = done_r;
    assign retire_cnt    = retire_cnt_r;
    assign halted        = halted_r;
    assign illegal       = illegal_r;

    // Instruction decode from the latched instruction register.
    always_comb begin
        dec_kind_s = K_ILL;
        dec_op_s   = OP_ADD;
        case (instr_r[31:26])
            6'b000001: begin
                case (instr_r[5:0])
                    6'b100000: begin dec_kind_s = K_ALU; dec_op_s = OP_ADD; end
                    6'b100010: begin dec_kind_s = K_ALU; dec_op_s = OP_SUB; end
                    6'b100100: begin dec_kind_s = K_ALU; dec_op_s = OP_AND; end
                    6'b100101: begin dec_kind_s = K_ALU; dec_op_s = OP_OR;  end
                    6'b110010: begin dec_kind_s = K_ALU; dec_op_s = OP_MUL; end
                    default:   begin dec_kind_s = K_ILL; dec_op_s = OP_ADD; end
                endcase
            end
            6'b000010: begin dec_kind_s = K_LOAD;  dec_op_s = OP_ADD; end
            6'b000011: begin dec_kind_s = K_STORE; dec_op_s = OP_ADD; end
            6'b000000: begin
                if (instr_r == 32'h0000_0000) begin
                    dec_kind_s = K_NOP;
                end else begin
                    dec_kind_s = K_ILL;
                end
            end
            6'b111111: begin dec_kind_s = K_HALT; dec_op_s = OP_ADD; end
            default:   begin dec_kind_s = K_ILL;  dec_op_s = OP_ADD; end
        endcase
    end

    // An instruction retires when its last state completes: NOP decode,
    // acknowledged store, or write-back.
    always_comb begin
        retire_s = 1'b0;
        if (state_r == S_DECODE && dec_kind_s == K_NOP) begin
            retire_s = 1'b1;
        end else if (state_r == S_MEM && kind_r == K_STORE && mem.dmem_ready) begin
            retire_s = 1'b1;
        end else if (state_r == S_WB) begin
            retire_s = 1'b1;
        end else begin
            retire_s = 1'b0;
        end
    end

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_BOOT;
            kind_r       <= K_NOP;
            mcnt_r       <= CNT_ZERO;
            pc_r         <= PC_ZERO;
            instr_r      <= 32'h0000_0000;
            alu_op_r     <= OP_ADD;
            alu_en_r     <= 1'b0;
            imem_req_r   <= 1'b0;
            dmem_re_r    <= 1'b0;
            dmem_we_r    <= 1'b0;
            rf_we_r      <= 1'b0;
            done_r       <= 1'b0;
            retire_cnt_r <= 16'd0;
            halted_r     <= 1'b0;
            illegal_r    <= 1'b0;
        end else begin
            case (state_r)
                S_BOOT: begin
                    state_r    <= S_FETCH;
                    imem_req_r <= 1'b1;
                end
                S_FETCH: begin
                    if (mem.imem_ready) begin
                        instr_r    <= mem.imem_data;
                        imem_req_r <= 1'b0;
                        state_r    <= S_DECODE;
                    end else begin
                        imem_req_r <= 1'b1;
                    end
                end
                S_DECODE: begin
                    kind_r <= dec_kind_s;
                    case (dec_kind_s)
                        K_ALU, K_LOAD, K_STORE: begin
                            state_r  <= S_EXEC;
                            alu_en_r <= 1'b1;
                            alu_op_r <= dec_op_s;
                            mcnt_r   <= (dec_op_s == OP_MUL) ? MULT_LOAD : CNT_ZERO;
                        end
                        K_NOP: begin
                            state_r    <= S_FETCH;
                            imem_req_r <= 1'b1;
                        end
                        K_HALT: begin
                            state_r  <= S_HALT;
                            halted_r <= 1'b1;
                        end
                        default: begin
                            state_r   <= S_ERR;
                            illegal_r <= 1'b1;
                        end
                    endcase
                end
                S_EXEC: begin
                    if (mcnt_r != CNT_ZERO) begin
                        mcnt_r <= mcnt_r - CNT_ONE;
                    end else begin
                        alu_en_r <= 1'b0;
                        alu_op_r <= OP_ADD;
                        case (kind_r)
                            K_LOAD: begin
                                state_r   <= S_MEM;
                                dmem_re_r <= 1'b1;
                            end
                            K_STORE: begin
                                state_r   <= S_MEM;
                                dmem_we_r <= 1'b1;
                            end
                            default: begin
                                state_r <= S_WB;
                                rf_we_r <= 1'b1;
                            end
                        endcase
                    end
                end
                S_MEM: begin
                    // Strobes are held unchanged until the data memory acknowledges.
                    if (mem.dmem_ready) begin
                        dmem_re_r <= 1'b0;
                        dmem_we_r <= 1'b0;
                        if (kind_r == K_LOAD) begin
                            state_r <= S_WB;
                            rf_we_r <= 1'b1;
                        end else begin
                            state_r    <= S_FETCH;
                            imem_req_r <= 1'b1;
                        end
                    end else begin
                        state_r <= S_MEM;
                    end
                end
                S_WB: begin
                    rf_we_r    <= 1'b0;
                    state_r    <= S_FETCH;
                    imem_req_r <= 1'b1;
                end
                S_HALT: begin
                    state_r    <= S_HALT;
                    imem_req_r <= 1'b0;
                end
                S_ERR: begin
                    state_r    <= S_ERR;
                    imem_req_r <= 1'b0;
                end
                default: begin
                    state_r    <= S_ERR;
                    illegal_r  <= 1'b1;
                    imem_req_r <= 1'b0;
                    alu_en_r   <= 1'b0;
                    alu_op_r   <= OP_ADD;
                    dmem_re_r  <= 1'b0;
                    dmem_we_r  <= 1'b0;
                    rf_we_r    <= 1'b0;
                end
            endcase

            if (retire_s) begin
                done_r       <= 1'b1;
                retire_cnt_r <= retire_cnt_r + 16'd1;
                pc_r         <= pc_r + PC_ONE;
            end else begin
                done_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: randomized wait states and programs
// scored by a per-instruction transaction model.
module tb_instr_sequencer;

    localparam int PW    = 10;
    localparam int MC    = 4;
    localparam int DEPTH = 1 << PW;

    localparam int K_ALU = 0, K_MUL = 1, K_LOAD = 2, K_STORE = 3, K_NOP = 4, K_HALT = 5, K_ERR = 6;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] instr;
    logic [2:0]  alu_op;
    logic        alu_en, rf_we, instr_done, halted, illegal;
    logic [15:0] retire_cnt;

    instr_sequencer_if #(.PC_WIDTH(PW)) bus();

    instr_sequencer #(.PC_WIDTH(PW), .MULT_CYCLES(MC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem        (bus),
        .instr      (instr),
        .alu_op     (alu_op),
        .alu_en     (alu_en),
        .rf_we      (rf_we),
        .instr_done (instr_done),
        .retire_cnt (retire_cnt),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    logic [31:0] prog [DEPTH];
    int n_checks = 0, n_fail = 0, cyc = 0;
    int exp_pc, exp_cnt, start_cyc, force_dw;
    int iw, dw, iwc, dwc, n_alu, n_re, n_we, n_rf;
    bit started, stopped, rnd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Architectural meaning of an instruction word: class and ALU operation.
    function automatic void ref_decode(input logic [31:0] w, output int kind, output int op);
        logic [5:0] opc, fn;
        opc = w[31:26];
        fn  = w[5:0];
        kind = K_ERR;
        op   = 0;
        if (opc == 6'd1) begin
            if (fn == 6'h20)      begin kind = K_ALU; op = 0; end
            else if (fn == 6'h22) begin kind = K_ALU; op = 1; end
            else if (fn == 6'h24) begin kind = K_ALU; op = 2; end
            else if (fn == 6'h25) begin kind = K_ALU; op = 3; end
            else if (fn == 6'h32) begin kind = K_MUL; op = 4; end
        end else if (opc == 6'd2) kind = K_LOAD;
        else if (opc == 6'd3)     kind = K_STORE;
        else if (w == 32'h0)      kind = K_NOP;
        else if (opc == 6'h3F)    kind = K_HALT;
    endfunction

    function automatic int ref_cycles(input int kind, input int fw, input int mw);
        case (kind)
            K_ALU:   return 4 + fw;
            K_MUL:   return 3 + MC + fw;
            K_LOAD:  return 5 + fw + mw;
            K_STORE: return 4 + fw + mw;
            K_NOP:   return 2 + fw;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] rand_legal();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0:       return {6'd1, r[25:6], 6'h20};
            1:       return {6'd1, r[25:6], 6'h22};
            2:       return {6'd1, r[25:6], 6'h24};
            3:       return {6'd1, r[25:6], 6'h25};
            4:       return {6'd1, r[25:6], 6'h32};
            5:       return {6'd2, r[25:0]};
            6:       return {6'd3, r[25:0]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < DEPTH; i++) prog[i] = 32'hFC00_0000;
    endtask

    task automatic pick_waits();
        iw = rnd ? int'($urandom_range(0, 3)) : 0;
        dw = (force_dw >= 0) ? force_dw : (rnd ? int'($urandom_range(0, 3)) : 0);
        iwc = 0; dwc = 0; n_alu = 0; n_re = 0; n_we = 0; n_rf = 0;
    endtask

    task automatic monitor();
        int kind, op;
        ref_decode(prog[exp_pc], kind, op);
        if (alu_en) begin
            n_alu++;
            chk("alu_op", 64'(alu_op), 64'(op));
        end else begin
            chk("alu_op_idle", 64'(alu_op), 64'd0);
        end
        if (bus.dmem_re) n_re++;
        if (bus.dmem_we) n_we++;
        if (rf_we)       n_rf++;
        chk("strobe_excl", 64'(rf_we & (bus.dmem_re | bus.dmem_we)), 64'd0);
        if (!started && bus.imem_req) begin
            started   = 1'b1;
            start_cyc = cyc;
            pick_waits();
        end
        if (instr_done) begin
            chk("cycles", 64'(cyc - start_cyc), 64'(ref_cycles(kind, iw, dw)));
            chk("alu_cycles", 64'(n_alu), 64'((kind == K_MUL) ? MC : ((kind == K_NOP) ? 0 : 1)));
            chk("re_cycles", 64'(n_re), 64'((kind == K_LOAD) ? dw + 1 : 0));
            chk("we_cycles", 64'(n_we), 64'((kind == K_STORE) ? dw + 1 : 0));
            chk("rf_we_cycles", 64'(n_rf), 64'((kind <= K_LOAD) ? 1 : 0));
            chk("instr", 64'(instr), 64'(prog[exp_pc]));
            chk("retire_cnt", 64'(retire_cnt), 64'(16'(exp_cnt + 1)));
            exp_cnt++;
            exp_pc    = (exp_pc + 1) % DEPTH;
            start_cyc = cyc;
            pick_waits();
        end
        if (bus.imem_req) chk("imem_addr", 64'(bus.imem_addr), 64'(exp_pc));
        if (stopped) begin
            chk("stop_no_req", 64'(bus.imem_req), 64'd0);
            chk("stop_cnt", 64'(retire_cnt), 64'(16'(exp_cnt)));
        end else if (halted || illegal) begin
            stopped = 1'b1;
            chk("stop_lat", 64'(cyc - start_cyc), 64'(iw + 2));
            chk("halted", 64'(halted), 64'(kind == K_HALT));
            chk("illegal", 64'(illegal), 64'(kind == K_ERR));
        end
    endtask

    task automatic drive();
        if (bus.imem_req) begin
            if (iwc == iw) begin
                bus.imem_ready = 1'b1;
                bus.imem_data  = prog[exp_pc];
            end else begin
                iwc++;
                bus.imem_ready = 1'b0;
                bus.imem_data  = $urandom;
            end
        end else begin
            bus.imem_ready = 1'($urandom_range(0, 1));
            bus.imem_data  = $urandom;
        end
        if (bus.dmem_re || bus.dmem_we) begin
            if (dwc == dw) begin
                bus.dmem_ready = 1'b1;
            end else begin
                dwc++;
                bus.dmem_ready = 1'b0;
            end
        end else begin
            bus.dmem_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        monitor();
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_bus", 64'({bus.imem_req, bus.imem_addr, bus.dmem_re, bus.dmem_we}), 64'd0);
        chk("rst_out", 64'({alu_op, alu_en, rf_we, instr_done, retire_cnt, halted, illegal}), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        bus.imem_ready = 1'b0;
        bus.imem_data  = 32'h0;
        bus.dmem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        exp_pc  = 0;
        exp_cnt = 0;
        started = 1'b0;
        stopped = 1'b0;
        pick_waits();
        #1;
        chk("boot_no_req", 64'(bus.imem_req), 64'd0);
    endtask

    task automatic run_until(input int target, input int budget);
        int b;
        b = budget;
        while (exp_cnt < target && !stopped && b > 0) begin
            tick();
            b--;
        end
        if (exp_cnt < target && !stopped) chk("timeout", 64'd1, 64'd0);
    endtask

    initial begin
        rnd      = 1'b0;
        force_dw = -1;
        #3;

        clear_prog();
        prog[0] = 32'h08A0_1900;
        do_reset();
        run_until(1, 40);
        chk("load_next_pc", 64'(bus.imem_addr), 64'd1);

        clear_prog();
        prog[0] = 32'h0401_4032;
        prog[1] = 32'h0443_4820;
        prog[2] = 32'h0509_5022;
        prog[3] = 32'h0443_4825;
        prog[4] = 32'h0443_4824;
        prog[5] = 32'h0CAA_1CFF;
        do_reset();
        run_until(1000, 200);
        chk("halt_stop", 64'(stopped), 64'd1);
        repeat (6) tick();
        chk("halt_cnt", 64'(retire_cnt), 64'd6);

        clear_prog();
        prog[0]  = 32'h0CAA_1CFF;
        force_dw = 3;
        do_reset();
        run_until(1, 40);
        force_dw = -1;

        clear_prog();
        prog[0] = 32'h1400_0000;
        do_reset();
        run_until(1000, 40);
        chk("err_op_stop", 64'(stopped), 64'd1);
        repeat (6) tick();

        clear_prog();
        prog[0] = 32'h0400_003F;
        do_reset();
        run_until(1000, 40);
        chk("err_fn_stop", 64'(stopped), 64'd1);
        repeat (6) tick();

        rnd = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [5:0]  o;
            logic [31:0] r;
            o = 6'($urandom_range(4, 62));
            r = $urandom;
            clear_prog();
            for (int i = 0; i < 3; i++) prog[i] = rand_legal();
            prog[3] = {o, r[25:0]};
            do_reset();
            run_until(1000, 200);
            chk("rand_ill_stop", 64'(stopped), 64'd1);
            repeat (4) tick();
        end

        rnd = 1'b0;
        clear_prog();
        prog[0]  = 32'h08A0_1900;
        force_dw = 50;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.dmem_re) break;
        end
        chk("mem_reached", 64'(bus.dmem_re), 64'd1);
        chk("no_early_retire", 64'(retire_cnt), 64'd0);
        force_dw = -1;
        do_reset();
        run_until(1, 40);

        rnd = 1'b1;
        clear_prog();
        for (int i = 0; i < 80; i++) prog[i] = rand_legal();
        do_reset();
        run_until(1000, 4000);
        chk("rand_stop", 64'(stopped), 64'd1);
        chk("rand_cnt", 64'(retire_cnt), 64'd80);

        for (int i = 0; i < DEPTH; i++) prog[i] = 32'h0;
        do_reset();
        run_until(DEPTH + 3, 8000);
        chk("pc_wrap", 64'(bus.imem_addr), 64'd3);
        chk("wrap_cnt", 64'(retire_cnt), 64'(DEPTH + 3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
